internal_node_loader: RTL and testbench
=======================================

INTERNAL_NODE_LOADER -- requirements
Module: internal_node_loader

Interface
REQ-001 Parameter INTERNAL_WIDTH, 22, width of one packed node word: {median half, index half}.
REQ-002 Parameter NUM_NODES, 63, internal nodes written per load pass; 1..64 legal.
REQ-003 Parameter CNT_WIDTH, 7, node counter width, wide enough to hold NUM_NODES.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset; synchronous to clk, active-low.
REQ-006 start  input  1  single-cycle pulse; begins a load pass.
REQ-007 fsm_enable  input  1  tree I/O phase enable; the tree writes only while this is high.
REQ-008 in_valid  input  1  upstream half-word valid.
REQ-009 in_data  input  INTERNAL_WIDTH/2  upstream half-word; low half first, then high half.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 sender_enable  output  1  node-word write strobe to the tree.
REQ-012 sender_data  output  INTERNAL_WIDTH  packed node word to the tree.
REQ-013 node_count  output  CNT_WIDTH  nodes written in the current pass.
REQ-014 busy  output  1  high in LOAD.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 FSM states: IDLE, LOAD, DONE.
- IDLE->LOAD on start; node_count cleared to 0.
- LOAD->DONE on the cycle the write of node NUM_NODES-1 occurs.
- DONE->LOAD on start; node_count cleared to 0.
REQ-017 start in LOAD is ignored.
REQ-018 A half-word transfer occurs when in_valid and in_ready are both high.
REQ-019 in_ready = (state==LOAD) and no word is pending; it is low in IDLE and DONE.
REQ-020 The first transfer of a node is stored as the low half; half_sel then toggles.
REQ-021 On the second transfer, sender_data[INTERNAL_WIDTH-1:INTERNAL_WIDTH/2] takes in_data and sender_data[INTERNAL_WIDTH/2-1:0] takes the stored low half. The pending flag sets on the next edge.
REQ-022 sender_enable = pending and fsm_enable, combinational. The tree's write address counts only these strobes.
REQ-023 When sender_enable is high:
- pending clears at the next edge;
- node_count increments at the next edge;
- half_sel is already at the low position.
REQ-024 While pending is high and fsm_enable is low, sender_data is held stable and in_ready stays low. There is no overwrite and no data loss.
REQ-025 Peak throughput is one node per 3 cycles: low transfer, high transfer, write strobe.
REQ-026 sender_data holds its last value when not pending. It is don't-care to the tree when sender_enable is low.
REQ-027 node_count never exceeds NUM_NODES; it holds NUM_NODES in DONE until the next start.
REQ-028 in_valid outside LOAD is not consumed, because in_ready is low.
REQ-029 A start in the same cycle as the final write is ignored. A later start in DONE begins a new pass.

Reset
REQ-030 While rst_n is low at a rising edge, the block returns to:
- state IDLE;
- pending 0;
- half_sel low;
- node_count 0;
- sender_data 0.
REQ-031 Reset outputs: in_ready 0, sender_enable 0, busy 0, done 0.
REQ-032 Reset mid-pass discards any stored half and pending word. This stays aligned with the tree, whose write address resets on the same rst_n.

Structure
REQ-033 The shared KD-tree package holds:
- INTERNAL_WIDTH;
- NUM_NODES;
- the FSM state enum type.
REQ-034 One sub-module, internal_node_packer, holds the half-word assembly: half_sel, low-half register, pending, sender_data. The top level keeps the FSM and node_count.

Verification
REQ-035 Nominal pass: reset, start, fsm_enable=1, in_valid held high, in_data sequence 0x001,0x7FF repeated.
- sender_data = 0x3FF801 on every strobe;
- sender_enable pulses every 3 cycles;
- done rises after exactly 63 strobes;
- node_count = 63.
REQ-036 Backpressure: fsm_enable=0 with a word pending for 10 cycles.
- sender_enable stays 0, sender_data is stable, in_ready stays 0;
- on fsm_enable=1, exactly one strobe occurs.
REQ-037 Upstream gaps: in_valid random, about 30% duty.
- Strobed words match the scoreboard {hi,lo} order;
- there are no duplicate or skipped halves.
REQ-038 Reset mid-pass after 20 nodes plus one stored low half.
- All outputs take reset values;
- a new start and 63 nodes complete correctly, with the first word built from fresh halves.
REQ-039 Restart and ignore cases:
- start pulses during LOAD have no effect;
- start in DONE clears node_count to 0 and a second pass completes with done;
- in_valid in IDLE/DONE is never consumed.

Source files
------------

// File: rtl/internal_node_loader_pkg.sv
// ---------------------------------------------------------------------------
// internal_node_loader_pkg
// Shared KD-tree definitions used by the internal-node loader and its packer.
//   KD_INTERNAL_WIDTH : width of one packed node word {median half, index half}
//   KD_NUM_NODES      : internal nodes written per load pass (1..64)
//   KD_CNT_WIDTH      : node counter width, wide enough to hold KD_NUM_NODES
//   load_state_e      : loader FSM state encoding
// ---------------------------------------------------------------------------
package internal_node_loader_pkg;

    localparam int KD_INTERNAL_WIDTH = 22;
    localparam int KD_NUM_NODES      = 63;
    localparam int KD_CNT_WIDTH      = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

endpackage : internal_node_loader_pkg

// File: rtl/internal_node_loader_packer.sv
// ---------------------------------------------------------------------------
// internal_node_packer
// Assembles two upstream half-words (low half first) into one node word and
// holds it pending until the tree's I/O phase allows the write.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   load_en        : loader is in its LOAD state
//   fsm_enable     : tree I/O phase enable
//   in_valid/in_data/in_ready : upstream half-word handshake
//   sender_enable  : node-word write strobe (pending and fsm_enable)
//   sender_data    : packed node word {high half, low half}
// ---------------------------------------------------------------------------
module internal_node_packer
    import internal_node_loader_pkg::*;
#(
    parameter int INTERNAL_WIDTH = KD_INTERNAL_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_en,
    input  logic                        fsm_enable,
    input  logic                        in_valid,
    input  logic [INTERNAL_WIDTH/2-1:0] in_data,
    output logic                        in_ready,
    output logic                        sender_enable,
    output logic [INTERNAL_WIDTH-1:0]   sender_data
);

    localparam int HALF = INTERNAL_WIDTH / 2;

    logic                      half_sel_q, half_sel_d;
    logic [HALF-1:0]           lo_q, lo_d;
    logic                      pending_q, pending_d;
    logic [INTERNAL_WIDTH-1:0] data_q, data_d;
    logic                      xfer;

    // Upstream is stalled while a finished word waits for the tree, so a
    // pending word can never be overwritten.
    assign in_ready      = load_en & ~pending_q;
    assign xfer          = in_valid & in_ready;
    assign sender_enable = pending_q & fsm_enable;
    assign sender_data   = data_q;

    always_comb begin
        half_sel_d = half_sel_q;
        lo_d       = lo_q;
        pending_d  = pending_q;
        data_d     = data_q;

        // xfer and sender_enable are mutually exclusive: xfer needs !pending.
        if (sender_enable) begin
            pending_d = 1'b0;
        end

        if (xfer) begin
            if (!half_sel_q) begin
                lo_d       = in_data;
                half_sel_d = 1'b1;
            end else begin
                data_d     = {in_data, lo_q};
                pending_d  = 1'b1;
                half_sel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            half_sel_q <= 1'b0;
            lo_q       <= '0;
            pending_q  <= 1'b0;
            data_q     <= '0;
        end else begin
            half_sel_q <= half_sel_d;
            lo_q       <= lo_d;
            pending_q  <= pending_d;
            data_q     <= data_d;
        end
    end

endmodule : internal_node_packer

// File: rtl/internal_node_loader.sv
// ---------------------------------------------------------------------------
// internal_node_loader
// Loads NUM_NODES packed internal-node words into the KD-tree. Each node is
// received as two half-words and written with one strobe while fsm_enable
// is high.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : single-cycle pulse, begins a pass (IDLE or DONE only)
//   fsm_enable      : tree I/O phase enable
//   in_valid/in_data/in_ready : upstream half-word handshake
//   sender_enable   : node-word write strobe to the tree
//   sender_data     : packed node word to the tree
//   node_count      : nodes written in the current pass
//   busy / done     : FSM in LOAD / FSM in DONE
// ---------------------------------------------------------------------------
module internal_node_loader
    import internal_node_loader_pkg::*;
#(
    parameter int INTERNAL_WIDTH = KD_INTERNAL_WIDTH,
    parameter int NUM_NODES      = KD_NUM_NODES,
    parameter int CNT_WIDTH      = KD_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        fsm_enable,
    input  logic                        in_valid,
    input  logic [INTERNAL_WIDTH/2-1:0] in_data,
    output logic                        in_ready,
    output logic                        sender_enable,
    output logic [INTERNAL_WIDTH-1:0]   sender_data,
    output logic [CNT_WIDTH-1:0]        node_count,
    output logic                        busy,
    output logic                        done
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_NODES - 1);

    load_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] node_count_q, node_count_d;
    logic                 load_en;
    logic                 last_write;

    internal_node_packer #(
        .INTERNAL_WIDTH (INTERNAL_WIDTH)
    ) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_en       (load_en),
        .fsm_enable    (fsm_enable),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .sender_enable (sender_enable),
        .sender_data   (sender_data)
    );

    // The strobe for node NUM_NODES-1 ends the pass.
    assign last_write = sender_enable && (node_count_q == LAST_IDX);
    assign node_count = node_count_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured outside LOAD.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)      state_d = ST_LOAD;
            ST_LOAD: if (last_write) state_d = ST_DONE;
            ST_DONE: if (start)      state_d = ST_LOAD;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy    = (state_q == ST_LOAD);
        done    = (state_q == ST_DONE);
        load_en = (state_q == ST_LOAD);
    end

    // Node counter: cleared when a pass begins, counts tree write strobes.
    always_comb begin
        node_count_d = node_count_q;
        if ((state_q != ST_LOAD) && start) begin
            node_count_d = '0;
        end else if ((state_q == ST_LOAD) && sender_enable) begin
            node_count_d = node_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            node_count_q <= '0;
        end else begin
            node_count_q <= node_count_d;
        end
    end

endmodule : internal_node_loader

// File: tb/tb_internal_node_loader.sv
// ---------------------------------------------------------------------------
// tb_internal_node_loader
// Randomized scoreboard bench. Accepted half-words feed a reference model
// that pairs them into {hi,lo} node words; a negedge monitor compares every
// write strobe against the oldest expected word.
// ---------------------------------------------------------------------------
module tb_internal_node_loader;
    import internal_node_loader_pkg::*;

    localparam int W  = KD_INTERNAL_WIDTH;
    localparam int H  = W / 2;
    localparam int N  = KD_NUM_NODES;
    localparam int CW = KD_CNT_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          fsm_enable = 1'b0;
    logic          in_valid = 1'b0;
    logic [H-1:0]  in_data = '0;
    logic          in_ready;
    logic          sender_enable;
    logic [W-1:0]  sender_data;
    logic [CW-1:0] node_count;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    internal_node_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .fsm_enable    (fsm_enable),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .sender_enable (sender_enable),
        .sender_data   (sender_data),
        .node_count    (node_count),
        .busy          (busy),
        .done          (done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [H-1:0] half_q[$];
    logic [W-1:0] exp_q[$];
    int           strobes = 0;
    int           cyc = 0;
    int           last_strobe_cyc = -1;
    bit           check_period = 1'b0;
    bit           done_due = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] want;
        cyc++;
        if (!rst_n) begin
            half_q.delete();
            exp_q.delete();
            strobes = 0;
            last_strobe_cyc = -1;
            done_due = 1'b0;
        end else begin
            if (done_due) begin
                check("done_after_last_strobe", 32'(done), 32'd1);
                done_due = 1'b0;
            end
            if (sender_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_strobe: sender_data=0x%0h with no word expected", sender_data);
                end else begin
                    want = exp_q.pop_front();
                    check("sender_data", 32'(sender_data), 32'(want));
                    check("node_count_at_strobe", 32'(node_count), 32'(strobes));
                    check("done_before_last", 32'(done), 32'd0);
                    if (check_period && last_strobe_cyc >= 0)
                        check("strobe_period", 32'(cyc - last_strobe_cyc), 32'd3);
                    last_strobe_cyc = cyc;
                    strobes++;
                    $display("strobe %0d data=0x%06h", strobes, sender_data);
                    if (strobes == N) done_due = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                half_q.push_back(in_data);
                if (half_q.size() == 2) begin
                    exp_q.push_back({half_q[1], half_q[0]});
                    half_q.delete();
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_sender_enable", 32'(sender_enable), 32'd0);
        check("rst_sender_data", 32'(sender_data), 32'd0);
        check("rst_node_count", 32'(node_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic start_pass();
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        strobes = 0;
        last_strobe_cyc = -1;
        check("start_busy", 32'(busy), 32'd1);
        check("start_node_count", 32'(node_count), 32'd0);
        check("start_done", 32'(done), 32'd0);
    endtask

    task automatic finish_pass(input int valid_pct, input int en_pct, input bit nominal, input bit noise);
        int c;
        for (c = 0; c < 5000 && !done; c++) begin
            in_valid   = nominal ? 1'b1 : ($urandom_range(0, 99) < valid_pct);
            in_data    = nominal ? ((half_q.size() == 0) ? 11'h001 : 11'h7FF) : H'($urandom);
            fsm_enable = (en_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < en_pct);
            start      = noise && ($urandom_range(0, 99) < 5);
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0; fsm_enable = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL pass_timeout: done not seen, strobes=%0d", strobes);
        end
        @(posedge clk); #1;
        check("pass_done", 32'(done), 32'd1);
        check("pass_busy", 32'(busy), 32'd0);
        check("pass_node_count", 32'(node_count), 32'(N));
        check("pass_strobes", 32'(strobes), 32'(N));
        check("pass_words_left", 32'(exp_q.size() + half_q.size()), 32'd0);
        $display("pass complete: strobes=%0d node_count=%0d", strobes, node_count);
    endtask

    task automatic idle_probe(input int n);
        repeat (n) begin
            in_valid = 1'b1;
            in_data  = H'($urandom);
            @(posedge clk); #1;
            check("in_ready_outside_load", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int c;
        int s0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        idle_probe(5);

        // Nominal pass: 0x001 / 0x7FF halves, full throughput
        check_period = 1'b1;
        start_pass();
        finish_pass(100, 100, 1'b1, 1'b0);
        check_period = 1'b0;
        idle_probe(5);
        check("done_holds_count", 32'(node_count), 32'(N));

        // Backpressure: word pending with fsm_enable low
        start_pass();
        fsm_enable = 1'b0;
        in_valid   = 1'b1;
        for (c = 0; c < 20 && exp_q.size() == 0; c++) begin
            in_data = H'($urandom);
            @(posedge clk); #1;
        end
        check("bp_word_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 1) begin
            repeat (10) begin
                in_data = H'($urandom);
                @(posedge clk); #1;
                check("bp_sender_enable", 32'(sender_enable), 32'd0);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_sender_data", 32'(sender_data), 32'(exp_q[0]));
            end
        end
        in_valid   = 1'b0;
        fsm_enable = 1'b1;
        s0 = strobes;
        repeat (3) @(posedge clk);
        #1;
        check("bp_one_strobe", 32'(strobes - s0), 32'd1);
        finish_pass(100, 100, 1'b0, 1'b0);

        // Upstream gaps, random fsm_enable
        start_pass();
        finish_pass(30, 70, 1'b0, 1'b0);

        // Reset mid-pass after 20 nodes plus one stored low half
        start_pass();
        fsm_enable = 1'b1;
        for (c = 0; c < 300 && !(strobes == 20 && half_q.size() == 1); c++) begin
            in_valid = 1'b1;
            in_data  = H'($urandom);
            @(posedge clk); #1;
        end
        check("mid_reached_20", 32'(strobes), 32'd20);
        check("mid_low_stored", 32'(half_q.size()), 32'd1);
        do_reset();
        start_pass();
        finish_pass(100, 100, 1'b0, 1'b0);

        // Start pulses during LOAD ignored; restart from DONE
        start_pass();
        finish_pass(60, 80, 1'b0, 1'b1);
        idle_probe(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_internal_node_loader
